// File: rtl/twobitcomp_bist.sv
// Built-in self-test sweep for the 2-bit magnitude comparator.
// Walks all 16 operand pairs, checks g/l/e, reports pass and first failure.
module twobitcomp_bist #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       x1,
  output logic       x0,
  output logic       y1,
  output logic       y0,
  input  logic       g,
  input  logic       l,
  input  logic       e,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] fail_count,
  output logic       first_fail_valid,
  output logic [3:0] first_fail_vec
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [3:0] RELOAD = 4'(SETTLE - 1);

  state_t     state, state_nx;
  logic [3:0] vec, vec_nx;
  logic [3:0] wcnt, wcnt_nx;
  logic [4:0] fcnt_nx;
  logic       ffv_nx;
  logic [3:0] ffvec_nx;

  logic [1:0] opx, opy;
  logic [2:0] expect_gle;
  logic       mismatch;

  assign opx = vec[3:2];
  assign opy = vec[1:0];
  assign expect_gle = {opx > opy, opx < opy, opx == opy};
  // Exact three-bit match; multi-hot or all-zero responses fail.
  assign mismatch = {g, l, e} != expect_gle;

  assign x1 = vec[3];
  assign x0 = vec[2];
  assign y1 = vec[1];
  assign y0 = vec[0];

  assign busy = (state == S_WAIT) || (state == S_CHECK);
  assign done = (state == S_DONE);
  assign pass = done && (fail_count == 5'd0);

  always_comb begin
    state_nx = state;
    vec_nx   = vec;
    wcnt_nx  = wcnt;
    fcnt_nx  = fail_count;
    ffv_nx   = first_fail_valid;
    ffvec_nx = first_fail_vec;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nx = S_WAIT;
          vec_nx   = 4'd0;
          wcnt_nx  = RELOAD;
          fcnt_nx  = 5'd0;
          ffv_nx   = 1'b0;
          ffvec_nx = 4'd0;
        end
      end
      S_WAIT: begin
        if (wcnt == 4'd0) begin
          state_nx = S_CHECK;
        end else begin
          wcnt_nx = wcnt - 4'd1;
        end
      end
      S_CHECK: begin
        if (mismatch) begin
          fcnt_nx = fail_count + 5'd1;
          if (!first_fail_valid) begin
            ffv_nx   = 1'b1;
            ffvec_nx = vec;
          end
        end
        if (vec == 4'd15) begin
          state_nx = S_DONE;
        end else begin
          vec_nx   = vec + 4'd1;
          wcnt_nx  = RELOAD;
          state_nx = S_WAIT;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      vec              <= 4'd0;
      wcnt             <= 4'd0;
      fail_count       <= 5'd0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= 4'd0;
    end else begin
      state            <= state_nx;
      vec              <= vec_nx;
      wcnt             <= wcnt_nx;
      fail_count       <= fcnt_nx;
      first_fail_valid <= ffv_nx;
      first_fail_vec   <= ffvec_nx;
    end
  end

endmodule

// File: tb/tb_twobitcomp_bist.sv
// Directed bench for twobitcomp_bist: two instances (SETTLE=1 and 3)
// each wired to a behavioural comparator with selectable faults.
module tb_twobitcomp_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start_a, start_b;
  logic [1:0] mode_a, mode_b;

  logic x1_a, x0_a, y1_a, y0_a, g_a, l_a, e_a;
  logic busy_a, done_a, pass_a, ffv_a;
  logic [4:0] fc_a;
  logic [3:0] ffvec_a;

  logic x1_b, x0_b, y1_b, y0_b, g_b, l_b, e_b;
  logic busy_b, done_b, pass_b, ffv_b;
  logic [4:0] fc_b;
  logic [3:0] ffvec_b;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc;

  // mode 0: correct, 1: e stuck at 0, 2: g and l swapped
  function automatic logic [2:0] cmp_model(input logic [1:0] m,
                                           input logic [3:0] v);
    logic [1:0] xv, yv;
    logic [2:0] r;
    xv = v[3:2];
    yv = v[1:0];
    r = {xv > yv, xv < yv, xv == yv};
    if (m == 2'd1) r[0] = 1'b0;
    if (m == 2'd2) r = {r[1], r[2], r[0]};
    return r;
  endfunction

  always_comb {g_a, l_a, e_a} = cmp_model(mode_a, {x1_a, x0_a, y1_a, y0_a});
  always_comb {g_b, l_b, e_b} = cmp_model(mode_b, {x1_b, x0_b, y1_b, y0_b});

  twobitcomp_bist #(.SETTLE(1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a),
    .x1(x1_a), .x0(x0_a), .y1(y1_a), .y0(y0_a),
    .g(g_a), .l(l_a), .e(e_a),
    .busy(busy_a), .done(done_a), .pass(pass_a),
    .fail_count(fc_a),
    .first_fail_valid(ffv_a), .first_fail_vec(ffvec_a)
  );

  twobitcomp_bist #(.SETTLE(3)) dut_b (
    .clk(clk), .rst(rst), .start(start_b),
    .x1(x1_b), .x0(x0_b), .y1(y1_b), .y0(y0_b),
    .g(g_b), .l(l_b), .e(e_b),
    .busy(busy_b), .done(done_b), .pass(pass_b),
    .fail_count(fc_b),
    .first_fail_valid(ffv_b), .first_fail_vec(ffvec_b)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sweep_a(input bit hold, output int c);
    start_a = 1'b1;
    tick();
    if (!hold) start_a = 1'b0;
    c = 0;
    while (!done_a && c < 200) begin
      if (c < 32) chk("walk_a", int'({x1_a, x0_a, y1_a, y0_a}), c / 2);
      chk("busy_a", int'(busy_a), 1);
      chk("pass_low_a", int'(pass_a), 0);
      tick();
      c++;
    end
    chk("busy_done_a", int'(busy_a), 0);
  endtask

  task automatic sweep_b(output int c);
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    c = 0;
    while (!done_b && c < 300) begin
      if (c < 64) chk("walk_b", int'({x1_b, x0_b, y1_b, y0_b}), c / 4);
      chk("busy_b", int'(busy_b), 1);
      tick();
      c++;
    end
  endtask

  task automatic chk_reset_a();
    chk("rst_vec", int'({x1_a, x0_a, y1_a, y0_a}), 0);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_done", int'(done_a), 0);
    chk("rst_pass", int'(pass_a), 0);
    chk("rst_fc", int'(fc_a), 0);
    chk("rst_ffv", int'(ffv_a), 0);
    chk("rst_ffvec", int'(ffvec_a), 0);
  endtask

  initial begin
    rst = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    mode_a = 2'd0;
    mode_b = 2'd0;
    tick();
    tick();
    chk_reset_a();
    // rst wins over start
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("rst_prio_busy", int'(busy_a), 0);
    rst = 1'b0;
    tick();

    // clean sweep, SETTLE=1
    sweep_a(1'b0, cyc);
    chk("lat_clean", cyc, 32);
    chk("done_clean", int'(done_a), 1);
    chk("pass_clean", int'(pass_a), 1);
    chk("fc_clean", int'(fc_a), 0);
    chk("ffv_clean", int'(ffv_a), 0);
    tick();
    tick();
    chk("hold_done", int'(done_a), 1);
    chk("hold_vec", int'({x1_a, x0_a, y1_a, y0_a}), 15);

    // e stuck at 0: vectors 0,5,10,15 fail
    mode_a = 2'd1;
    sweep_a(1'b0, cyc);
    chk("lat_estuck", cyc, 32);
    chk("fc_estuck", int'(fc_a), 4);
    chk("ffv_estuck", int'(ffv_a), 1);
    chk("ffvec_estuck", int'(ffvec_a), 0);
    chk("pass_estuck", int'(pass_a), 0);

    // g/l swapped: 12 unequal vectors fail, first is 0001
    mode_a = 2'd2;
    sweep_a(1'b0, cyc);
    chk("fc_swap", int'(fc_a), 12);
    chk("ffvec_swap", int'(ffvec_a), 1);
    chk("ffv_swap", int'(ffv_a), 1);
    chk("pass_swap", int'(pass_a), 0);

    // SETTLE=3 instance
    sweep_b(cyc);
    chk("lat_s3", cyc, 64);
    chk("pass_s3", int'(pass_b), 1);
    chk("fc_s3", int'(fc_b), 0);

    // reset mid-sweep at vec 7
    mode_a = 2'd0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (14) tick();
    chk("mid_vec7", int'({x1_a, x0_a, y1_a, y0_a}), 7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_a();
    sweep_a(1'b0, cyc);
    chk("lat_after_rst", cyc, 32);
    chk("pass_after_rst", int'(pass_a), 1);

    // start held high throughout; restart from DONE
    mode_a = 2'd1;
    sweep_a(1'b1, cyc);
    chk("lat_hold", cyc, 32);
    chk("fc_hold", int'(fc_a), 4);
    tick();
    chk("rs_done", int'(done_a), 0);
    chk("rs_busy", int'(busy_a), 1);
    chk("rs_fc", int'(fc_a), 0);
    chk("rs_ffv", int'(ffv_a), 0);
    chk("rs_vec", int'({x1_a, x0_a, y1_a, y0_a}), 0);
    start_a = 1'b0;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/twobitcomp_bist.md
# twobitcomp_bist

Built-in self-test controller for the 2-bit magnitude comparator (`twobitcomp`). On `start`, it drives all 16 input combinations into the comparator in binary order, waits a programmable settle time, and samples the comparator's `g`/`l`/`e` response. It checks each response against a golden model and reports pass/fail, the failure count and the first failing vector. It sits beside the comparator instance and replaces the exhaustive software sweep with synthesizable hardware.

## Interface
- `SETTLE`, default 1: cycles between driving a vector and sampling the response. Legal range is 1..15.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  begin sweep. Sampled only in IDLE or DONE.
- `x1`, `x0`  out  1 each  operand X bits, MSB and LSB, driven to the comparator.
- `y1`, `y0`  out  1 each  operand Y bits, MSB and LSB, driven to the comparator.
- `g`, `l`, `e`  in  1 each  comparator response: greater, less, equal.
- `busy`  out  1  high in WAIT and CHECK.
- `done`  out  1  high in DONE.
- `pass`  out  1  high in DONE when `fail_count` == 0; otherwise 0.
- `fail_count`  out  5  number of mismatching vectors, 0..16.
- `first_fail_valid`  out  1  at least one mismatch recorded.
- `first_fail_vec`  out  4  index of the first mismatching vector.

## Operation
- Vector register `vec[3:0]` is registered. Outputs are driven combinationally from it: `x1`=vec[3], `x0`=vec[2], `y1`=vec[1], `y0`=vec[0].
  - X = {x1,x0}, Y = {y1,y0}, unsigned.
  - The sweep order is 0000, 0001, …, 1111.
- Golden model: expected g = (X>Y), l = (X<Y), e = (X==Y).
  - A vector passes only if all three bits match exactly.
  - Any multi-hot or all-zero response is therefore a fail.
- FSM states:
  - IDLE:
    - `start`=1 → clear `vec`, `fail_count`, `first_fail_*`; load `wcnt`=SETTLE-1; go to WAIT.
  - WAIT:
    - `wcnt`==0 → go to CHECK.
    - Otherwise decrement `wcnt`.
  - CHECK:
    - Compare `g`/`l`/`e` against the golden model this cycle.
    - On mismatch, increment `fail_count`.
    - On mismatch with `first_fail_valid`=0, set `first_fail_vec`=vec and `first_fail_valid`=1.
    - If `vec`==15 → go to DONE; `vec` holds at 15.
    - Otherwise increment `vec`, reload `wcnt`=SETTLE-1, go to WAIT.
  - DONE:
    - Hold all results.
    - `start`=1 → same actions as from IDLE (restart).
- `start` is ignored in WAIT and CHECK; no queuing.
- `vec` never wraps during a sweep. The increment is suppressed at 15.
- `fail_count` saturates naturally at 16; overflow is not possible.

## Timing
- Reset (`rst`=1 at an edge) → next cycle:
  - state IDLE, `vec`=0, so `x1`/`x0`/`y1`/`y0`=0;
  - `busy`=0, `done`=0, `pass`=0;
  - `fail_count`=0, `first_fail_valid`=0, `first_fail_vec`=0.
- Reset mid-sweep aborts immediately with the same values. `rst` has priority over `start`.
- Vector k is driven for exactly SETTLE+1 cycles: SETTLE WAIT cycles, then 1 CHECK cycle.
- Sampling happens in the last cycle of that window. The comparator's combinational path must settle within SETTLE cycles.
- `start` edge at cycle 0 → `done` rises at cycle 16·(SETTLE+1).
  - With SETTLE=1, `done` rises at cycle 32.
- The CHECK result of vector 15 is reflected in `fail_count` on the same edge that `done` rises.
- `busy` and `done` are never high together.
- `pass` is 0 whenever `done`=0.

## Test plan
- Correct `twobitcomp` attached, SETTLE=1, pulse `start` → `done`=1 exactly 32 cycles later, `pass`=1, `fail_count`=0, `first_fail_valid`=0. Outputs walk 0000…1111, each held 2 cycles.
- Comparator model with `e` stuck at 0 → `fail_count`=4 (vectors 0, 5, 10, 15), `first_fail_vec`=0, `pass`=0.
- Model with `g` and `l` swapped → `fail_count`=12, `first_fail_vec`=1 (X=00, Y=01 expects l=1), `pass`=0.
- SETTLE=3, correct model → `done` at cycle 64. Each vector held 4 cycles.
- Assert `rst` while `vec`=7 → next cycle all outputs are at reset values. A subsequent `start` completes a full clean sweep with `pass`=1.
- Hold `start` high for the whole sweep → no restart while busy; `done` at cycle 32. With `start` still high in DONE, a new sweep begins on the next edge: `done`=0, `busy`=1, counters cleared.
